count_disp: RTL and testbench
=============================

COUNT_DISP -- requirements
Module: count_disp

Interface
REQ-001 Parameter REFRESH_DIV, default 4: clock cycles per digit slot, legal range 2..65535.
REQ-002 Parameter BLANK_LZ, default 1: when 1, a leading tens digit of zero is blanked.
REQ-003 Parameter SEG_ACTIVE_LOW, default 0: when 1, seg is bitwise inverted at the output.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-006 count_in  in  4  unsigned value from the upstream up-counter, 0..15.
REQ-007 seg  out  7  segment drive; bit0=a … bit6=g; active-high unless SEG_ACTIVE_LOW.
REQ-008 an  out  2  digit enable, one-hot or zero; an[0]=ones, an[1]=tens.
REQ-009 wrap  out  1  one-cycle pulse on a count_in wrap 15->0.
REQ-010 wrap_cnt  out  8  number of wraps seen since reset, saturating.

Function
REQ-011 Prescaler counts 0..REFRESH_DIV-1 and rolls over; tick is high for one cycle when the prescaler equals REFRESH_DIV-1.
REQ-012 FSM states are S_ONES and S_TENS; on a tick the FSM goes S_ONES->S_TENS or S_TENS->S_ONES; with no tick the state holds.
REQ-013 Frame boundary = tick while in S_TENS; on that edge disp_reg loads count_in, and both digits of the next frame show the new value.
REQ-014 count_in changes between frame boundaries do not affect seg or an (tear-free display).
REQ-015 tens = 1 if disp_reg >= 10, else 0; ones = disp_reg - 10*tens (always 0..9).
REQ-016 In S_ONES: an = 2'b01 and seg = decode(ones).
REQ-017 In S_TENS: an = 2'b10 and seg = decode(tens); exception: tens = 0 and BLANK_LZ = 1 gives an = 2'b00 and seg = decode(0).
REQ-018 Decode table (active-high hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
REQ-019 seg and an are combinational from state and disp_reg only; count_in reaches them only through disp_reg.
REQ-020 prev_count registers count_in every cycle.
REQ-021 wrap is registered: it is high on the cycle after the edge where prev_count = 15 and count_in = 0, and lasts exactly one cycle.
REQ-022 15->15, 15->1, 14->15 and 0->0 produce no wrap.
REQ-023 wrap_cnt increments on each wrap pulse, saturates at 255 and never rolls over.

Reset
REQ-024 rst = 0 immediately forces the following, with no clock required:
- prescaler = 0, state = S_ONES, disp_reg = 0, prev_count = 0;
- wrap = 0, wrap_cnt = 0;
- therefore an = 2'b01 and seg = 7'h3F (inverted if SEG_ACTIVE_LOW).
REQ-025 After rst rises, the first tick occurs REFRESH_DIV cycles later; the first frame boundary occurs 2*REFRESH_DIV cycles later.
REQ-026 Reset asserted mid-frame or mid-wrap-pulse discards all state; no pulse or latch completes.

Structure
REQ-027 Shared package count_pkg holds:
- the state enum (S_ONES, S_TENS);
- the ten 7-bit segment constants;
- digit width = 4 and the wrap_cnt width = 8.
REQ-028 One sub-module, seg7_dec: combinational 4-bit digit to 7-bit active-high segments; values 10..15 give 7'h00.
REQ-029 count_disp instantiates seg7_dec exactly once, on the digit selected for the current slot.

Verification (REFRESH_DIV=4 unless stated)
REQ-030 rst=0 with count_in=9 -> seg=3F, an=01, wrap=0, wrap_cnt=0, with no clock edge.
REQ-031 count_in=7 held, release rst:
- cycles 0-3: an=01, seg=3F;
- after cycle 8: an=01 with seg=07, then an=00 (BLANK_LZ=1);
- with BLANK_LZ=0 the tens slot instead shows an=10, seg=3F.
REQ-032 count_in=13 latched -> ones slot seg=4F, tens slot seg=06; an alternates every 4 cycles.
REQ-033 count_in=5 latched, switched to 12 two cycles after a boundary -> seg keeps 6D/blank until the next boundary, then shows 5B/06.
REQ-034 Drive sequence 14,15,0,0,15,1 -> exactly one wrap pulse, one cycle after the 15->0 edge, and wrap_cnt=1; then 300 further wraps -> wrap_cnt=255.
REQ-035 Assert rst asynchronously while an=10 -> an=01, seg=3F and wrap_cnt=0 at once; the next tick comes 4 cycles after release.

Source files
------------

// File: rtl/count_pkg.sv
// Shared types and constants for the two-digit count display.
package count_pkg;

    localparam int DIGIT_W    = 4;
    localparam int WRAP_CNT_W = 8;

    typedef enum logic {
        S_ONES = 1'b0,
        S_TENS = 1'b1
    } state_e;

    // Active-high segment patterns, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

endpackage

// File: rtl/seg7_dec.sv
// Digit to active-high seven-segment decoder; non-decimal codes light nothing.
module seg7_dec
    import count_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [6:0]         seg_o
);

    always_comb begin
        seg_o = 7'h00;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = 7'h00;
        endcase
    end

endmodule

// File: rtl/count_disp.sv
// Multiplexed two-digit display of a 0..15 count, with 15->0 wrap detection.
//   state  | meaning
//   S_ONES | ones digit driven on an[0]
//   S_TENS | tens digit driven on an[1] (or blanked when zero)
module count_disp
    import count_pkg::*;
#(
    parameter int REFRESH_DIV    = 4,
    parameter int BLANK_LZ       = 1,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGIT_W-1:0]    count_in,
    output logic [6:0]            seg,
    output logic [1:0]            an,
    output logic                  wrap,
    output logic [WRAP_CNT_W-1:0] wrap_cnt
);

    localparam logic [15:0] PRE_MAX = 16'(REFRESH_DIV - 1);

    logic [15:0]           presc_q, presc_d;
    state_e                state_q, state_d;
    logic [DIGIT_W-1:0]    disp_q, disp_d;
    logic [DIGIT_W-1:0]    prev_q;
    logic                  wrap_q;
    logic [WRAP_CNT_W-1:0] wrap_cnt_q;

    logic                  tick;
    logic                  tens;
    logic [DIGIT_W-1:0]    ones;
    logic [DIGIT_W-1:0]    digit;
    logic [6:0]            seg_raw;

    assign tick = (presc_q == PRE_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            state_q <= S_ONES;
            disp_q  <= '0;
        end else begin
            presc_q <= presc_d;
            state_q <= state_d;
            disp_q  <= disp_d;
        end
    end

    always_comb begin
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        state_d = state_q;
        disp_d  = disp_q;
        if (tick) begin
            case (state_q)
                S_ONES: state_d = S_TENS;
                S_TENS: begin
                    state_d = S_ONES;
                    // Frame boundary: the only point where count_in enters the display.
                    disp_d  = count_in;
                end
                default: state_d = S_ONES;
            endcase
        end
    end

    always_comb begin
        tens  = (disp_q >= 4'd10);
        ones  = tens ? (disp_q - 4'd10) : disp_q;
        digit = ones;
        an    = 2'b01;
        if (state_q == S_TENS) begin
            digit = {3'b000, tens};
            an    = (!tens && (BLANK_LZ != 0)) ? 2'b00 : 2'b10;
        end
    end

    seg7_dec u_dec (
        .digit_i (digit),
        .seg_o   (seg_raw)
    );

    assign seg = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q     <= '0;
            wrap_q     <= 1'b0;
            wrap_cnt_q <= '0;
        end else begin
            prev_q <= count_in;
            wrap_q <= (prev_q == 4'd15) && (count_in == 4'd0);
            if (wrap_q && (wrap_cnt_q != '1))
                wrap_cnt_q <= wrap_cnt_q + 1'b1;
        end
    end

    assign wrap     = wrap_q;
    assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_count_disp.sv
// Directed bench for count_disp: default instance plus an unblanked, inverted-segment instance.
module tb_count_disp;

    logic       clk;
    logic       rst;
    logic [3:0] count_in;
    logic [6:0] seg, seg2;
    logic [1:0] an, an2;
    logic       wrap, wrap2;
    logic [7:0] wrap_cnt, wrap_cnt2;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;
    logic [3:0] seq [6] = '{4'd14, 4'd15, 4'd0, 4'd0, 4'd15, 4'd1};

    count_disp #(.REFRESH_DIV(4), .BLANK_LZ(1), .SEG_ACTIVE_LOW(0)) u_dut (
        .clk(clk), .rst(rst), .count_in(count_in),
        .seg(seg), .an(an), .wrap(wrap), .wrap_cnt(wrap_cnt)
    );

    count_disp #(.REFRESH_DIV(4), .BLANK_LZ(0), .SEG_ACTIVE_LOW(1)) u_dut2 (
        .clk(clk), .rst(rst), .count_in(count_in),
        .seg(seg2), .an(an2), .wrap(wrap2), .wrap_cnt(wrap_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        // Reset with no clock edge yet
        rst = 1'b0;
        count_in = 4'd9;
        #1;
        chk("rst_seg", seg, 7'h3F);
        chk("rst_an", an, 2'b01);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_wcnt", wrap_cnt, 8'd0);
        chk("rst_seg_inv", seg2, 7'h40);

        count_in = 4'd7;
        @(negedge clk);
        rst = 1'b1;
        chk("c0_an", an, 2'b01);
        for (int k = 1; k <= 3; k++) begin
            edges(1);
            chk("c123_an", an, 2'b01);
            chk("c123_seg", seg, 7'h3F);
        end
        edges(1);   // edge 4: tens slot, disp still 0
        chk("e4_an_blank", an, 2'b00);
        chk("e4_seg", seg, 7'h3F);
        chk("e4_an_noblank", an2, 2'b10);
        chk("e4_seg_noblank", seg2, 7'h40);
        edges(4);   // edge 8: first frame boundary
        chk("e8_an", an, 2'b01);
        chk("e8_seg7", seg, 7'h07);
        chk("e8_seg7_inv", seg2, 7'h78);
        edges(4);   // edge 12
        chk("e12_an_blank", an, 2'b00);
        chk("e12_an2", an2, 2'b10);
        count_in = 4'd13;
        edges(4);   // edge 16
        chk("e16_an", an, 2'b01);
        chk("e16_seg3", seg, 7'h4F);
        edges(1);
        chk("e17_an", an, 2'b01);
        edges(3);   // edge 20
        chk("e20_an", an, 2'b10);
        chk("e20_seg1", seg, 7'h06);
        chk("e20_seg1_inv", seg2, 7'h79);

        count_in = 4'd5;
        edges(4);   // edge 24
        chk("e24_seg5", seg, 7'h6D);
        edges(2);   // edge 26: mid-frame change
        count_in = 4'd12;
        edges(1);
        chk("e27_seg5_hold", seg, 7'h6D);
        chk("e27_an", an, 2'b01);
        edges(1);
        chk("e28_an_blank", an, 2'b00);
        chk("e28_seg", seg, 7'h3F);
        edges(4);   // edge 32
        chk("e32_seg2", seg, 7'h5B);
        chk("e32_an", an, 2'b01);
        edges(4);   // edge 36
        chk("e36_seg1", seg, 7'h06);
        chk("e36_an", an, 2'b10);

        // Wrap detection
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            count_in = seq[i];
            edges(1);
            if (wrap) pulses++;
            if (i == 2) chk("wrap_pulse", wrap, 1'b1);
            if (i == 3) chk("wrap_cnt1", wrap_cnt, 8'd1);
        end
        for (int i = 0; i < 2; i++) begin
            edges(1);
            if (wrap) pulses++;
        end
        chk("wrap_pulses", pulses, 1);
        chk("wrap_cnt_after", wrap_cnt, 8'd1);

        for (int i = 0; i < 200; i++) begin
            count_in = 4'd15; edges(1);
            count_in = 4'd0;  edges(1);
        end
        edges(3);
        chk("wrap_cnt201", wrap_cnt, 8'd201);
        for (int i = 0; i < 100; i++) begin
            count_in = 4'd15; edges(1);
            count_in = 4'd0;  edges(1);
        end
        edges(3);
        chk("wrap_cnt_sat", wrap_cnt, 8'd255);
        chk("wrap_cnt_sat2", wrap_cnt2, 8'd255);

        // Asynchronous reset during the tens slot
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            edges(1);
            if (an2 == 2'b10) found = 1'b1;
        end
        chk("find_tens", found, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("arst_an", an, 2'b01);
        chk("arst_an2", an2, 2'b01);
        chk("arst_seg", seg, 7'h3F);
        chk("arst_wcnt", wrap_cnt, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        edges(3);
        chk("rel_e3_an2", an2, 2'b01);
        edges(1);
        chk("rel_e4_an2", an2, 2'b10);

        // Reset during a wrap pulse
        count_in = 4'd15; edges(1);
        count_in = 4'd0;  edges(1);
        chk("pre_rst_wrap", wrap, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("rst_wrap_kill", wrap, 1'b0);
        chk("rst_wrap_cnt", wrap_cnt, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        edges(2);
        chk("post_rst_wcnt", wrap_cnt, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
